// File: rtl/lmg_drain_sequencer_if.sv
// lmg_drain_sequencer_if
//   Bundles the two buses that lmg_drain_sequencer drives while a run is active:
//   the LMG control/FIFO read side and the One_Mib_RAM write port.
//   master : the sequencer (drives lmg_reset, lmg_rden, ram_*).
//   slave  : the LMG + RAM side (drives lmg_done, lmg_fifo_out, lmg_fifo_empty).
//   Signals:
//     lmg_reset      one-cycle reset pulse to the LMG
//     lmg_done       LMG finished generating
//     lmg_rden       FIFO read request, data valid the following cycle
//     lmg_fifo_out   packed FIFO word, slot k at [SLOT_W*k +: SLOT_W]
//     lmg_fifo_empty FIFO empty
//     ram_wren       RAM write enable
//     ram_wraddr     RAM write address
//     ram_data       RAM write data
interface lmg_drain_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 15,
  parameter int SLOTS      = 8,
  parameter int SLOT_W     = 19
);
  logic                       lmg_reset;
  logic                       lmg_done;
  logic                       lmg_rden;
  logic [SLOTS*SLOT_W-1:0]    lmg_fifo_out;
  logic                       lmg_fifo_empty;
  logic                       ram_wren;
  logic [ADDR_WIDTH-1:0]      ram_wraddr;
  logic [DATA_WIDTH-1:0]      ram_data;

  modport master (
    output lmg_reset, lmg_rden, ram_wren, ram_wraddr, ram_data,
    input  lmg_done, lmg_fifo_out, lmg_fifo_empty
  );

  modport slave (
    input  lmg_reset, lmg_rden, ram_wren, ram_wraddr, ram_data,
    output lmg_done, lmg_fifo_out, lmg_fifo_empty
  );
endinterface

// File: rtl/lmg_drain_sequencer.sv
// lmg_drain_sequencer
//   Runs one legal-move-generator pass: pulses the LMG reset, waits for LMG
//   done, drains the packed move FIFO word by word, writes each valid 19-bit
//   slot into consecutive RAM words after base_addr, then writes a count
//   header at base_addr and a zero terminator after the last move.
//   Owns the RAM write port while busy.
//
//   Optional build macro: LMG_DRAIN_TIMEOUT_EN
//     adds the timeout output and a WAIT-state watchdog of TIMEOUT_CYC cycles
//     that ends the run with an empty list.
//
//   Ports:
//     clk         system clock
//     reset       asynchronous active-low reset
//     start       level request; rising edge begins a run, low aborts it
//     base_addr   header address, sampled on the start rising edge
//     busy        run in progress
//     done        run complete, held until start falls
//     move_count  moves stored in the current/last run
//     overflow    at least one valid move was discarded
//     timeout     watchdog expired (LMG_DRAIN_TIMEOUT_EN only)
//     bus         LMG + RAM write bus (master side)
module lmg_drain_sequencer #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 15,
  parameter int SLOTS       = 8,
  parameter int SLOT_W      = 19,
  parameter int CNT_WIDTH   = 8,
  parameter int MAX_MOVES   = 255,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  move_count,
  output logic                  overflow,
`ifdef LMG_DRAIN_TIMEOUT_EN
  output logic                  timeout,
`endif
  lmg_drain_sequencer_if.master bus
);

  localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int WORD_W = SLOTS * SLOT_W;

  if (MAX_MOVES > (2 ** CNT_WIDTH) - 1) begin : g_bad_max_moves
    $error("MAX_MOVES does not fit in CNT_WIDTH");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [3:0] {
    IDLE,
    LRST,
    WAIT,
    RDREQ,
    RDWAIT,
    UNPACK,
    WR_CNT,
    WR_TERM,
    DONE
  } state_t;

  state_t                 state_q, state_d;
  logic                   start_q;
  logic [ADDR_WIDTH-1:0]  base_q, base_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic [WORD_W-1:0]      word_q, word_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   wren_q, wren_d;
  logic [ADDR_WIDTH-1:0]  waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;

`ifdef LMG_DRAIN_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            tmo_q, tmo_d;
`endif

  logic              start_rise;
  logic              abort;
  logic              all_invalid;
  logic [SLOT_W-1:0] slot;

  assign start_rise = start && !start_q;
  assign abort      = !start && (state_q != IDLE) && (state_q != DONE);
  assign slot       = word_q[int'(idx_q) * SLOT_W +: SLOT_W];

  // End-of-list marker: every slot carries its invalid flag.
  always_comb begin
    all_invalid = 1'b1;
    for (int unsigned k = 0; k < SLOTS; k++) begin
      all_invalid = all_invalid & bus.lmg_fifo_out[k*SLOT_W + SLOT_W - 1];
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    word_d  = word_q;
    idx_d   = idx_q;
    wren_d  = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
`ifdef LMG_DRAIN_TIMEOUT_EN
    wd_d    = wd_q;
    tmo_d   = tmo_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start_rise) begin
          base_d  = base_addr;
          cnt_d   = '0;
          ovf_d   = 1'b0;
`ifdef LMG_DRAIN_TIMEOUT_EN
          tmo_d   = 1'b0;
`endif
          state_d = LRST;
        end
      end
      LRST: begin
`ifdef LMG_DRAIN_TIMEOUT_EN
        wd_d    = '0;
`endif
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.lmg_done) begin
          state_d = RDREQ;
        end
`ifdef LMG_DRAIN_TIMEOUT_EN
        else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
          tmo_d   = 1'b1;
          state_d = WR_CNT;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      RDREQ: begin
        state_d = bus.lmg_fifo_empty ? WR_CNT : RDWAIT;
      end
      RDWAIT: begin
        word_d = bus.lmg_fifo_out;
        if (all_invalid) begin
          state_d = WR_CNT;
        end else begin
          idx_d   = '0;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        if (!slot[SLOT_W-1]) begin
          if (cnt_q != CNT_WIDTH'(MAX_MOVES)) begin
            wren_d  = 1'b1;
            waddr_d = base_q + ADDR_WIDTH'(1) + ADDR_WIDTH'(cnt_q);
            wdata_d = DATA_WIDTH'(slot[SLOT_W-2:0]);
            cnt_d   = cnt_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (idx_q == IDX_W'(SLOTS - 1)) begin
          state_d = RDREQ;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      WR_CNT: begin
        wren_d                       = 1'b1;
        waddr_d                      = base_q;
        wdata_d                      = '0;
        wdata_d[CNT_WIDTH-1:0]       = cnt_q;
        wdata_d[DATA_WIDTH-1]        = ovf_q;
        state_d                      = WR_TERM;
      end
      WR_TERM: begin
        wren_d  = 1'b1;
        waddr_d = base_q + ADDR_WIDTH'(cnt_q) + ADDR_WIDTH'(1);
        wdata_d = '0;
        state_d = DONE;
      end
      DONE: begin
        if (!start) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides whatever the current state decided this cycle; the
    // counters keep the values they had before the aborting cycle.
    if (abort) begin
      state_d = IDLE;
      wren_d  = 1'b0;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
`ifdef LMG_DRAIN_TIMEOUT_EN
      tmo_d   = tmo_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      base_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      word_q  <= '0;
      idx_q   <= '0;
      wren_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
`ifdef LMG_DRAIN_TIMEOUT_EN
      wd_q    <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      start_q <= start;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      wren_q  <= wren_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
`ifdef LMG_DRAIN_TIMEOUT_EN
      wd_q    <= wd_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign busy       = (state_q != IDLE) && (state_q != DONE);
  assign done       = (state_q == DONE);
  assign move_count = cnt_q;
  assign overflow   = ovf_q;
`ifdef LMG_DRAIN_TIMEOUT_EN
  assign timeout    = tmo_q;
`endif

  assign bus.lmg_reset  = (state_q == LRST);
  // Gated by start so an aborting cycle never pops a FIFO word.
  assign bus.lmg_rden   = (state_q == RDREQ) && !bus.lmg_fifo_empty && start;
  assign bus.ram_wren   = wren_q;
  assign bus.ram_wraddr = waddr_q;
  assign bus.ram_data   = wdata_q;

endmodule

// File: doc/lmg_drain_sequencer.md
Name: lmg_drain_sequencer

Overview:
- Sequences one legal-move-generator (LMG) run for the Avalon control block.
- Pulses the LMG reset, waits for LMG done, then drains the packed move FIFO one 152-bit word at a time.
- Unpacks the valid 19-bit slots into consecutive block-RAM words, then writes a count header and a zero terminator.
- Sits between the control register file (start, base address) and the One_Mib_RAM write port, and owns that port while busy.

Parameters:
- DATA_WIDTH, 32: RAM word width.
- ADDR_WIDTH, 15: RAM address width.
- SLOTS, 8: move slots per FIFO word.
- SLOT_W, 19: slot width; bit 18 is the invalid flag, bits 17:0 are the move.
- CNT_WIDTH, 8: move counter width.
- MAX_MOVES, 255: maximum moves stored per run; must be ≤ 2^CNT_WIDTH-1.
- TIMEOUT_CYC, 4096: watchdog limit, used only with the optional feature.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-low reset.
- start, in, 1: level request; a rising edge begins a run.
- base_addr, in, ADDR_WIDTH: header address; sampled on the start rising edge.
- busy, out, 1: high from the start edge until DONE or abort.
- done, out, 1: high in DONE until start falls.
- move_count, out, CNT_WIDTH: moves stored in the current or last run.
- overflow, out, 1: at least one valid move was discarded.
- lmg_reset, out, 1: one-cycle reset pulse to the LMG.
- lmg_done, in, 1: LMG finished generating.
- lmg_rden, out, 1: FIFO read request; data is valid the following cycle.
- lmg_fifo_out, in, SLOTS*SLOT_W: packed word; slot k occupies bits [19k+18:19k].
- lmg_fifo_empty, in, 1: FIFO empty.
- ram_wren, out, 1: RAM write enable.
- ram_wraddr, out, ADDR_WIDTH: RAM write address.
- ram_data, out, DATA_WIDTH: RAM write data.
- timeout, out, 1: watchdog expired; present only with the optional feature.

Behaviour:
- Reset values: all outputs 0; state IDLE; counter, slot index and word register cleared.
- start is registered; a rising edge is start high while its registered copy is low.
- States and transitions:
  - IDLE: on a rising edge, latch base_addr, clear move_count and overflow, set busy, go to LRST.
  - LRST: lmg_reset=1 for exactly 1 cycle; go to WAIT.
  - WAIT: hold until lmg_done=1, then go to RDREQ.
  - RDREQ: if lmg_fifo_empty, go to WR_CNT with no read issued. Otherwise lmg_rden=1 for 1 cycle; go to RDWAIT.
  - RDWAIT: capture lmg_fifo_out into the word register.
    - If every slot's invalid flag is 1, go to WR_CNT; that word is the end marker.
    - Otherwise set slot index to 0 and go to UNPACK.
  - UNPACK: one slot per cycle, index 0..SLOTS-1, including invalid slots.
    - Valid slot and move_count<MAX_MOVES: ram_wren=1, ram_wraddr=base+1+move_count, ram_data=zero-extended move; move_count+1.
    - Valid slot and move_count==MAX_MOVES: no write; overflow=1.
    - After slot SLOTS-1, go to RDREQ.
  - WR_CNT: ram_wren=1, ram_wraddr=base, ram_data={overflow, zeros, move_count}; go to WR_TERM.
  - WR_TERM: ram_wren=1, ram_wraddr=base+move_count+1, ram_data=0; go to DONE.
  - DONE: done=1, busy=0. When start=0, go to IDLE and clear done.
- Address arithmetic is modulo 2^ADDR_WIDTH; a wrap is not flagged.
- Fixed latency:
  - start edge → lmg_reset: 1 cycle.
  - lmg_done → first rden: 1 cycle.
  - Each non-terminal word: 10 cycles (RDREQ, RDWAIT, 8×UNPACK).
  - Terminal word → done: 3 cycles.
- Abort: start=0 in any state except IDLE or DONE → IDLE next cycle. No further RAM writes or rden; done stays 0; busy=0. move_count and overflow keep their last values.
- Start rising edge outside IDLE: ignored.
- lmg_done dropping after WAIT: ignored.
- Asynchronous reset mid-run: immediate return to reset values; any write in progress is dropped.
- ram_wren, ram_wraddr and ram_data are registered and change only on clk.

Optional Feature:
- Macro: LMG_DRAIN_TIMEOUT_EN.
- Defined:
  - The timeout port exists and a watchdog counts cycles in WAIT.
  - On reaching TIMEOUT_CYC, set timeout=1 and go to WR_CNT with move_count=0, producing a valid empty list.
  - timeout clears on the next start rising edge or on reset.
- Undefined: no timeout port, no counter; WAIT holds indefinitely.

Test Plan:
- Nominal run: base_addr=16; word 1 has slots 0,2,5 valid with moves 0x00111, 0x00222, 0x00333; word 2 is all invalid → RAM[17..19]=0x111, 0x222, 0x333; RAM[16]=3; RAM[20]=0; move_count=3; done=1 at 3 cycles after the word-2 capture.
- Empty FIFO at the first RDREQ → no rden; RAM[16]=0, RAM[17]=0; done=1, overflow=0.
- MAX_MOVES=4 with 10 valid moves across 2 words, then an all-invalid word → exactly 4 move writes; RAM[base]=0x80000004; overflow=1; terminator written at base+5.
- Drop start during UNPACK slot 3 → no RAM writes from the next cycle onward; busy=0 one cycle later; done stays 0. A new start edge runs cleanly from a cleared count.
- Assert reset for 1 cycle during WAIT → all outputs read 0 immediately; with no start edge, lmg_done=1 causes no rden.
- With LMG_DRAIN_TIMEOUT_EN and TIMEOUT_CYC=16, lmg_done held at 0 → timeout=1 after 16 cycles in WAIT; RAM[base]=0; RAM[base+1]=0; done=1.
